// File: rtl/id_issue_stage_if.sv
// Handshake, operand-bundle and writeback signals between the issue stage and its neighbours.
// The slave modport is the issue stage; master is the fetch/execute/writeback side.
interface id_issue_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] imm_val_r;
    logic [5:0]  alu_control;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    modport master (
        output in_valid, instr, out_ready, wb_valid, wb_rd, wb_data,
        input  in_ready, out_valid, src1, src2, imm_val_r, alu_control, rd, rd_we, illegal
    );

    modport slave (
        input  in_valid, instr, out_ready, wb_valid, wb_rd, wb_data,
        output in_ready, out_valid, src1, src2, imm_val_r, alu_control, rd, rd_we, illegal
    );
endinterface

// File: rtl/id_issue_stage.sv
// RV32I ALU decode/issue stage: register file with writeback bypass, RAW/WAW scoreboard,
// and a one-deep registered operand bundle for the execute ALU.
module id_issue_stage #(
    parameter logic [5:0] ILLEGAL_CODE = 6'b000000
) (
    input  logic              clk,
    input  logic              rst,
    id_issue_stage_if.slave   bus
);
    logic [6:0]  opcode;
    logic [4:0]  rd_f, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        is_r, legal;
    logic [5:0]  ctrl;
    logic [31:0] imm;

    logic [31:0] regs [32];
    logic [31:0] pending, pending_nxt;
    logic [31:0] rs1_val, rs2_val;
    logic        haz_rs1, haz_rs2, haz_rd, hazard, accept;

    logic        out_valid_q, rd_we_q, illegal_q;
    logic [31:0] src1_q, src2_q, imm_q;
    logic [5:0]  ctrl_q;
    logic [4:0]  rd_q;

    assign opcode = bus.instr[6:0];
    assign rd_f   = bus.instr[11:7];
    assign f3     = bus.instr[14:12];
    assign rs1    = bus.instr[19:15];
    assign rs2    = bus.instr[24:20];
    assign f7     = bus.instr[31:25];
    assign is_r   = (opcode == 7'b0110011);

    always_comb begin
        legal = 1'b0;
        ctrl  = ILLEGAL_CODE;
        imm   = '0;
        if (is_r) begin
            legal = 1'b1;
            case ({f7, f3})
                {7'b0000000, 3'b000}: ctrl = 6'b000001;
                {7'b0100000, 3'b000}: ctrl = 6'b000010;
                {7'b0000000, 3'b001}: ctrl = 6'b000011;
                {7'b0000000, 3'b010}: ctrl = 6'b000100;
                {7'b0000000, 3'b011}: ctrl = 6'b000101;
                {7'b0000000, 3'b100}: ctrl = 6'b000110;
                {7'b0000000, 3'b101}: ctrl = 6'b000111;
                {7'b0100000, 3'b101}: ctrl = 6'b001000;
                {7'b0000000, 3'b110}: ctrl = 6'b001001;
                {7'b0000000, 3'b111}: ctrl = 6'b001010;
                default:              legal = 1'b0;
            endcase
        end else if (opcode == 7'b0010011) begin
            legal = 1'b1;
            imm   = {{20{bus.instr[31]}}, bus.instr[31:20]};
            case (f3)
                3'b000: ctrl = 6'b001011;
                3'b010: ctrl = 6'b001101;
                3'b011: ctrl = 6'b000101;
                3'b100: ctrl = 6'b001111;
                3'b110: ctrl = 6'b001001;
                3'b111: ctrl = 6'b001110;
                3'b001: begin
                    imm = {27'd0, bus.instr[24:20]};
                    if (f7 == 7'b0000000) ctrl = 6'b001100;
                    else                  legal = 1'b0;
                end
                default: begin
                    imm = {27'd0, bus.instr[24:20]};
                    if (f7 == 7'b0000000)      ctrl = 6'b010000;
                    else if (f7 == 7'b0100000) ctrl = 6'b001000;
                    else                       legal = 1'b0;
                end
            endcase
        end
        if (!legal) begin
            ctrl = ILLEGAL_CODE;
            imm  = '0;
        end
    end

    // Read ports with writeback bypass; x0 is hard-wired to zero.
    always_comb begin
        rs1_val = regs[rs1];
        if (rs1 == 5'd0)                               rs1_val = '0;
        else if (bus.wb_valid && bus.wb_rd == rs1)     rs1_val = bus.wb_data;
    end

    always_comb begin
        rs2_val = regs[rs2];
        if (rs2 == 5'd0)                               rs2_val = '0;
        else if (bus.wb_valid && bus.wb_rd == rs2)     rs2_val = bus.wb_data;
    end

    // A pending register being written back this cycle is no longer a hazard.
    assign haz_rs1 = (rs1 != 5'd0) && pending[rs1]  && !(bus.wb_valid && bus.wb_rd == rs1);
    assign haz_rs2 = (rs2 != 5'd0) && pending[rs2]  && !(bus.wb_valid && bus.wb_rd == rs2);
    assign haz_rd  = (rd_f != 5'd0) && pending[rd_f] && !(bus.wb_valid && bus.wb_rd == rd_f);
    assign hazard  = haz_rs1 || (is_r && haz_rs2) || (legal && haz_rd);

    assign bus.in_ready = !rst && (!out_valid_q || bus.out_ready) && !hazard;
    assign accept       = bus.in_valid && bus.in_ready;

    // Set is applied after clear so a same-register set wins.
    always_comb begin
        pending_nxt = pending;
        if (bus.wb_valid)                       pending_nxt[bus.wb_rd] = 1'b0;
        if (accept && legal && rd_f != 5'd0)    pending_nxt[rd_f]      = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) pending <= '0;
        else     pending <= pending_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
        end else if (bus.wb_valid && bus.wb_rd != 5'd0) begin
            regs[bus.wb_rd] <= bus.wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            src1_q      <= '0;
            src2_q      <= '0;
            imm_q       <= '0;
            ctrl_q      <= '0;
            rd_q        <= '0;
            rd_we_q     <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            src1_q      <= legal ? rs1_val : '0;
            src2_q      <= !legal ? '0 : (is_r ? rs2_val : imm);
            imm_q       <= imm;
            ctrl_q      <= ctrl;
            rd_q        <= rd_f;
            rd_we_q     <= legal;
            illegal_q   <= !legal;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.src1        = src1_q;
    assign bus.src2        = src2_q;
    assign bus.imm_val_r   = imm_q;
    assign bus.alu_control = ctrl_q;
    assign bus.rd          = rd_q;
    assign bus.rd_we       = rd_we_q;
    assign bus.illegal     = illegal_q;
endmodule

// File: doc/id_issue_stage.md
# id_issue_stage

Decode/issue stage directly upstream of the execute ALU in the RISC-V core. Accepts one 32-bit RV32I ALU instruction per cycle over a valid/ready handshake, reads the 32×32 register file, and produces the registered operand bundle consumed by the ALU: `src1`, `src2`, `imm_val_r` and the 6-bit `alu_control` code. It owns the register file, accepts ALU results back on a writeback port, and tracks pending destination registers in a scoreboard so that it stalls on RAW and WAW hazards.

## Interface
- `ILLEGAL_CODE`, default 6'b000000: value driven on `alu_control` for an unsupported instruction.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: `instr` is valid.
- `in_ready` output 1: stage accepts `instr` this cycle.
- `instr` input 32: RV32I instruction word.
- `out_valid` output 1: operand bundle is valid for the ALU.
- `out_ready` input 1: ALU/execute consumes the bundle this cycle.
- `src1` output 32: rs1 value.
- `src2` output 32: rs2 value (R-type) or operand immediate (I-type).
- `imm_val_r` output 32: I-type immediate; 0 for R-type.
- `alu_control` output 6: ALU operation code.
- `rd` output 5: destination register.
- `rd_we` output 1: the bundle writes `rd`.
- `illegal` output 1: unsupported opcode/funct.
- `wb_valid` input 1: writeback strobe.
- `wb_rd` input 5: writeback register.
- `wb_data` input 32: writeback value.

## Operation
- Supported opcodes: 0110011 (R-type) and 0010011 (I-type).
- R-type `alu_control` mapping (by funct3/funct7[5]):
  - add 000001; sub 000010; sll 000011; slt 000100; sltu 000101
  - xor 000110; srl 000111; sra 001000; or 001001; and 001010
- I-type `alu_control` mapping:
  - addi 001011; slli 001100; slti 001101; andi 001110; xori 001111; srli 010000
  - ori 001001; srai 001000; sltiu 000101
- I-type operands:
  - `imm_val_r` = sign-extended `instr[31:20]`; `src2` = same value.
  - Shifts (slli/srli/srai): `src2` = `imm_val_r` = zero-extended `instr[24:20]`.
- Illegal instructions: any other opcode/funct combination, including shift-immediates with a wrong funct7. Response: `alu_control`=`ILLEGAL_CODE`, `illegal`=1, `rd_we`=0, `src1`/`src2`/`imm_val_r`=0. The bundle is still issued.
- Register file:
  - x0 always reads 0; writes to x0 are ignored.
  - Write on `wb_valid && wb_rd!=0`.
  - Read bypass: when `wb_valid && wb_rd==rsN && rsN!=0`, the read returns `wb_data`.
- Scoreboard (`pending[31:1]`):
  - Set `pending[rd]` on accept when `rd_we && rd!=0`.
  - Clear `pending[wb_rd]` on `wb_valid`.
  - Set and clear on the same register in the same cycle: set wins.
- Hazard condition: a source (rs1, and rs2 for R-type only) or the legal destination rd is pending and not being cleared by a `wb_valid` this cycle. Register x0 never causes a hazard.
- Ready rule: `in_ready = (!out_valid || out_ready) && !hazard`.
  - `in_ready` depends on `instr` and the scoreboard, never on `in_valid`.

## Timing
- Latency: one cycle. An instruction accepted at edge N appears on the outputs with `out_valid`=1 after edge N.
- Output register behaviour:
  - Holds stable while `out_valid && !out_ready`.
  - Loads a new bundle on accept.
  - Clears `out_valid` on `out_ready` when there is no accept.
  - Full throughput: back-to-back accept+consume every cycle.
- Reset, asserted at any edge:
  - `out_valid`=0; `src1`/`src2`/`imm_val_r`=0; `alu_control`=0; `rd`=0; `rd_we`=0; `illegal`=0.
  - All registers x1–x31 = 0; `pending`=0.
  - A held bundle is dropped.
  - `wb_valid` is ignored in a reset cycle.
- `in_ready` is 0 during reset cycles.
- Writeback in the same cycle as a read of that register: the bypass value is captured into `src1`/`src2`.

## Test plan
- Reset then x1 and x2 via wb (x1=5, x2=7). Issue add x3,x1,x2 -> next cycle `out_valid`=1, `src1`=5, `src2`=7, `alu_control`=000001, `rd`=3, `rd_we`=1.
- addi x4,x1,-3 -> `src2`=`imm_val_r`=0xFFFFFFFD, `alu_control`=001011. srai x5,x1,4 -> `src2`=`imm_val_r`=4, `alu_control`=001000.
- RAW stall: issue add x3,..., then sub x6,x3,x1 -> `in_ready`=0 until wb x3=12. On the wb cycle `in_ready`=1 and the captured `src1`=12 (bypass).
- Backpressure: hold `out_ready`=0 for 3 cycles with `in_valid`=1 -> outputs stable, `in_ready`=0. Then raise `out_ready` -> one bundle per cycle thereafter.
- Writes to x0: wb x0=0xFFFF then add x7,x0,x0 -> `src1`=`src2`=0. No stall for rd=x0 even with an outstanding write.
- Illegal/reset: opcode 0000011 -> `illegal`=1, `alu_control`=000000, `rd_we`=0. Assert `rst` while `out_valid`=1 and pending bits are set -> all outputs 0 and the next instruction issues without a stall.
